// File: rtl/mem_pkg.sv
// Shared types and widths for the mem_store block.
//   state_t : top-level FSM states
//   req_t   : kind of request latched in IDLE
package mem_pkg;

  localparam int ADR_W = 4;
  localparam int CMD_W = 16;
  localparam int DAT_W = 4;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    WR
  } state_t;

  typedef enum logic [1:0] {
    REQ_CMD,
    REQ_DAT,
    REQ_WR
  } req_t;

endpackage

// File: rtl/resp_timer.sv
// Response latency timer: a 3-bit down-counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val (takes priority over counting)
//   load_val   : start value, LATENCY-1
//   done       : high on the last waiting cycle (count == 1)
module resp_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       done
);

  logic [2:0] count;

  // NOTE: sequential state is updated with <= so every flop samples
  // pre-edge values; blocking assignments here would order-depend.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count == 3'd1);

endmodule

// File: rtl/mem_store.sv
// Command/operand store with a fixed-latency response.
//   clk, reset           : clock, synchronous active-high reset
//   giveC / giveD        : command-fetch / operand-read request (level)
//   write_data, wr_value : operand-write request and its value
//   ADR_1                : address for every request type
//   load_en/adr/cmd      : command-memory preload port (any state)
//   dv, com, data_t      : one-cycle response strobe and its payload
//   busy                 : FSM is not in IDLE
//   overrun              : a request was seen during WAIT or WR
module mem_store
  import mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = mem_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             giveC,
  input  logic             giveD,
  input  logic             write_data,
  input  logic [ADR_W-1:0] ADR_1,
  input  logic [DAT_W-1:0] wr_value,
  input  logic             load_en,
  input  logic [ADR_W-1:0] load_adr,
  input  logic [CMD_W-1:0] load_cmd,
  output logic             dv,
  output logic [CMD_W-1:0] com,
  output logic [DAT_W-1:0] data_t,
  output logic             busy,
  output logic             overrun
);

  localparam logic [2:0] LAT_LOAD = 3'(LATENCY - 1);

  logic [CMD_W-1:0] cmd_mem  [DEPTH];
  logic [DAT_W-1:0] data_mem [DEPTH];

  state_t           state, state_nx;
  req_t             req_type;
  logic [ADR_W-1:0] lat_adr;
  logic [CMD_W-1:0] lat_word;
  logic             timer_load;
  logic             timer_done;
  logic             any_req;

  assign any_req = giveC | giveD | write_data;
  assign busy    = (state != IDLE);

  resp_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .done     (timer_done)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (write_data) begin
          state_nx = WR;
        end else if (giveC || giveD) begin
          timer_load = 1'b1;
          state_nx   = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT:    if (timer_done) state_nx = RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and response path. The memory word is captured at the
  // sampling edge so later preloads cannot change an in-flight fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_type <= REQ_CMD;
      lat_adr  <= '0;
      lat_word <= '0;
      dv       <= 1'b0;
      com      <= '0;
      data_t   <= '0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_nx;
      dv      <= (state == RESP);
      overrun <= ((state == WAIT) || (state == WR)) && any_req;

      if (state == IDLE) begin
        if (write_data) begin
          req_type <= REQ_WR;
          lat_adr  <= ADR_1;
          lat_word <= {{(CMD_W-DAT_W){1'b0}}, wr_value};
        end else if (giveC) begin
          req_type <= REQ_CMD;
          lat_adr  <= ADR_1;
          lat_word <= cmd_mem[ADR_1];
        end else if (giveD) begin
          req_type <= REQ_DAT;
          lat_adr  <= ADR_1;
          lat_word <= {{(CMD_W-DAT_W){1'b0}}, data_mem[ADR_1]};
        end
      end

      if (state == RESP) begin
        com    <= (req_type == REQ_CMD) ? lat_word : '0;
        data_t <= (req_type == REQ_CMD) ? '0 : lat_word[DAT_W-1:0];
      end
    end
  end

  // NOTE: data_mem is a small flop array that must read back as zero
  // after reset, so it is cleared explicitly; cmd_mem has no reset and
  // keeps its preloaded contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= '0;
    end else if (state == WR) begin
      data_mem[lat_adr] <= lat_word[DAT_W-1:0];
    end
  end

  // Reset wins over a preload in the same cycle.
  always_ff @(posedge clk) begin
    if (load_en && !reset) cmd_mem[load_adr] <= load_cmd;
  end

endmodule

// File: tb/tb_mem_store.sv
// Directed bench for mem_store. Three instances (LATENCY 2, 3, 1) share
// the same inputs; each scenario checks the instance it targets.
module tb_mem_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        giveC, giveD, write_data;
  logic [3:0]  ADR_1, wr_value;
  logic        load_en;
  logic [3:0]  load_adr;
  logic [15:0] load_cmd;

  logic        dv_o   [3];
  logic [15:0] com_o  [3];
  logic [3:0]  dat_o  [3];
  logic        busy_o [3];
  logic        ovr_o  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_store #(.LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .giveC(giveC), .giveD(giveD),
    .write_data(write_data), .ADR_1(ADR_1), .wr_value(wr_value),
    .load_en(load_en), .load_adr(load_adr), .load_cmd(load_cmd),
    .dv(dv_o[0]), .com(com_o[0]), .data_t(dat_o[0]),
    .busy(busy_o[0]), .overrun(ovr_o[0]));

  mem_store #(.LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .giveC(giveC), .giveD(giveD),
    .write_data(write_data), .ADR_1(ADR_1), .wr_value(wr_value),
    .load_en(load_en), .load_adr(load_adr), .load_cmd(load_cmd),
    .dv(dv_o[1]), .com(com_o[1]), .data_t(dat_o[1]),
    .busy(busy_o[1]), .overrun(ovr_o[1]));

  mem_store #(.LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .giveC(giveC), .giveD(giveD),
    .write_data(write_data), .ADR_1(ADR_1), .wr_value(wr_value),
    .load_en(load_en), .load_adr(load_adr), .load_cmd(load_cmd),
    .dv(dv_o[2]), .com(com_o[2]), .data_t(dat_o[2]),
    .busy(busy_o[2]), .overrun(ovr_o[2]));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts negedges until dv of instance idx is seen (bounded); cycles is
  // -1 on timeout. rel drops all requests after the first sampling edge.
  task automatic wait_dv(input int idx, input bit rel,
                         output int cycles, output int ovr_cnt);
    cycles  = -1;
    ovr_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ovr_o[idx]) ovr_cnt++;
      if (rel && i == 1) begin
        giveC = 1'b0; giveD = 1'b0; write_data = 1'b0;
      end
      if (dv_o[idx]) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; giveC = 1'b0; giveD = 1'b0; write_data = 1'b0; load_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [3:0] adr, input logic [15:0] cmd);
    @(negedge clk);
    load_en = 1'b1; load_adr = adr; load_cmd = cmd;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic test_fetch_cmd();
    int c, ov;
    @(negedge clk);
    giveC = 1'b1; ADR_1 = 4'd0;
    @(negedge clk);
    giveC = 1'b0;
    n_checks++; if (dv_o[0] !== 1'b0) $display("FAIL fetch_early_dv: got %b expected 0", dv_o[0]); else n_pass++;
    n_checks++; if (busy_o[0] !== 1'b1) $display("FAIL fetch_busy: got %b expected 1", busy_o[0]); else n_pass++;
    wait_dv(0, 1'b0, c, ov);
    n_checks++; if (c !== 2) $display("FAIL fetch_latency: got %0d expected 2", c); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h1234) $display("FAIL fetch_com: got %h expected 1234", com_o[0]); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'h0) $display("FAIL fetch_data_t: got %h expected 0", dat_o[0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (dv_o[0] !== 1'b0) $display("FAIL fetch_dv_one_cycle: got %b expected 0", dv_o[0]); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h1234) $display("FAIL fetch_com_hold: got %h expected 1234", com_o[0]); else n_pass++;
    n_checks++; if (busy_o[0] !== 1'b0) $display("FAIL fetch_idle: got %b expected 0", busy_o[0]); else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    load_en = 1'b1; load_adr = 4'd3; load_cmd = 16'hBEEF;
    @(negedge clk);
    reset = 1'b0; load_en = 1'b0;
    n_checks++; if (dv_o[0] !== 1'b0) $display("FAIL reset_dv: got %b expected 0", dv_o[0]); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h0) $display("FAIL reset_com: got %h expected 0", com_o[0]); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'h0) $display("FAIL reset_data_t: got %h expected 0", dat_o[0]); else n_pass++;
    n_checks++; if (busy_o[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o[0]); else n_pass++;
    n_checks++; if (ovr_o[0] !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", ovr_o[0]); else n_pass++;
  endtask

  task automatic test_write_read();
    int c, ov;
    @(negedge clk);
    write_data = 1'b1; ADR_1 = 4'd5; wr_value = 4'hA;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (c !== 3) $display("FAIL wr_ack_latency: got %0d expected 3", c); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'hA) $display("FAIL wr_ack_data_t: got %h expected a", dat_o[0]); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h0) $display("FAIL wr_ack_com: got %h expected 0", com_o[0]); else n_pass++;
    // Read issued in the first IDLE cycle after the write's response.
    giveD = 1'b1; ADR_1 = 4'd5; wr_value = 4'h3;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (c !== 3) $display("FAIL rd_latency: got %0d expected 3", c); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'hA) $display("FAIL rd_after_wr: got %h expected a", dat_o[0]); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h0) $display("FAIL rd_com: got %h expected 0", com_o[0]); else n_pass++;
  endtask

  task automatic test_load_inflight();
    int c, ov;
    @(negedge clk);
    giveC = 1'b1; ADR_1 = 4'd3;
    @(negedge clk);
    giveC = 1'b0;
    load_en = 1'b1; load_adr = 4'd3; load_cmd = 16'h2222;
    @(negedge clk);
    load_en = 1'b0;
    wait_dv(0, 1'b0, c, ov);
    n_checks++; if (c !== 1) $display("FAIL inflight_latency: got %0d expected 1", c); else n_pass++;
    // 1111 also shows the BEEF load under reset was blocked.
    n_checks++; if (com_o[0] !== 16'h1111) $display("FAIL inflight_com: got %h expected 1111", com_o[0]); else n_pass++;
    giveC = 1'b1; ADR_1 = 4'd3;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (com_o[0] !== 16'h2222) $display("FAIL reload_com: got %h expected 2222", com_o[0]); else n_pass++;
  endtask

  task automatic test_priority();
    int c, ov;
    do_reset();
    @(negedge clk);
    write_data = 1'b1; giveC = 1'b1; giveD = 1'b1; ADR_1 = 4'd7; wr_value = 4'h6;
    wait_dv(0, 1'b0, c, ov);
    n_checks++; if (c !== 3) $display("FAIL prio_wr_latency: got %0d expected 3", c); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'h6 || com_o[0] !== 16'h0)
      $display("FAIL prio_wr_first: got com=%h data_t=%h expected com=0000 data_t=6", com_o[0], dat_o[0]); else n_pass++;
    write_data = 1'b0;
    wait_dv(0, 1'b0, c, ov);
    n_checks++; if (c !== 3) $display("FAIL prio_cmd_latency: got %0d expected 3", c); else n_pass++;
    n_checks++; if (com_o[0] !== 16'h00C7 || dat_o[0] !== 4'h0)
      $display("FAIL prio_cmd_second: got com=%h data_t=%h expected com=00c7 data_t=0", com_o[0], dat_o[0]); else n_pass++;
    giveC = 1'b0;
    wait_dv(0, 1'b0, c, ov);
    n_checks++; if (c !== 3) $display("FAIL prio_dat_latency: got %0d expected 3", c); else n_pass++;
    n_checks++; if (dat_o[0] !== 4'h6 || com_o[0] !== 16'h0)
      $display("FAIL prio_dat_third: got com=%h data_t=%h expected com=0000 data_t=6", com_o[0], dat_o[0]); else n_pass++;
    giveD = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o[0] !== 1'b0) $display("FAIL prio_done_idle: got %b expected 0", busy_o[0]); else n_pass++;
  endtask

  task automatic test_overrun();
    int c, ov, total, extra_dv, extra_ov;
    do_reset();
    total = 0; extra_dv = 0; extra_ov = 0;
    @(negedge clk);
    giveC = 1'b1; ADR_1 = 4'd0;
    @(negedge clk);
    if (ovr_o[1]) total++;
    giveC = 1'b0; giveD = 1'b1; ADR_1 = 4'd3;
    @(negedge clk);
    if (ovr_o[1]) total++;
    giveD = 1'b0;
    wait_dv(1, 1'b0, c, ov);
    total += ov;
    n_checks++; if (c !== 2) $display("FAIL ovr_latency: got %0d expected 2", c); else n_pass++;
    n_checks++; if (com_o[1] !== 16'h1234 || dat_o[1] !== 4'h0)
      $display("FAIL ovr_orig_resp: got com=%h data_t=%h expected com=1234 data_t=0", com_o[1], dat_o[1]); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dv_o[1]) extra_dv++;
      if (ovr_o[1]) extra_ov++;
    end
    n_checks++; if (total !== 1) $display("FAIL ovr_pulse_count: got %0d expected 1", total); else n_pass++;
    n_checks++; if (extra_dv !== 0) $display("FAIL ovr_extra_dv: got %0d expected 0", extra_dv); else n_pass++;
    n_checks++; if (extra_ov !== 0) $display("FAIL ovr_extra_pulse: got %0d expected 0", extra_ov); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int c, ov, seen;
    do_reset();
    @(negedge clk);
    write_data = 1'b1; ADR_1 = 4'd2; wr_value = 4'h9;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (dat_o[0] !== 4'h9) $display("FAIL abort_setup_wr: got %h expected 9", dat_o[0]); else n_pass++;
    // Fetch aborted in WAIT.
    giveC = 1'b1; ADR_1 = 4'd0;
    @(negedge clk);
    giveC = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy_o[0] !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_o[0]); else n_pass++;
    seen = dv_o[0] ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dv_o[0]) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL abort_no_dv: got %0d expected 0", seen); else n_pass++;
    // Write aborted in WR.
    write_data = 1'b1; ADR_1 = 4'd4; wr_value = 4'hF;
    @(negedge clk);
    write_data = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy_o[0] !== 1'b0 || dv_o[0] !== 1'b0)
      $display("FAIL abort_wr_state: got busy=%b dv=%b expected busy=0 dv=0", busy_o[0], dv_o[0]); else n_pass++;
    giveD = 1'b1; ADR_1 = 4'd2;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (c !== 3 || dat_o[0] !== 4'h0)
      $display("FAIL abort_mem2_cleared: got cycles=%0d data_t=%h expected cycles=3 data_t=0", c, dat_o[0]); else n_pass++;
    giveD = 1'b1; ADR_1 = 4'd4;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (dat_o[0] !== 4'h0) $display("FAIL abort_wr_blocked: got %h expected 0", dat_o[0]); else n_pass++;
    giveC = 1'b1; ADR_1 = 4'd0;
    wait_dv(0, 1'b1, c, ov);
    n_checks++; if (com_o[0] !== 16'h1234) $display("FAIL abort_cmd_kept: got %h expected 1234", com_o[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c, ov;
    logic [3:0]  adrs [3];
    logic [15:0] exps [3];
    adrs[0] = 4'd0; exps[0] = 16'h1234;
    adrs[1] = 4'd3; exps[1] = 16'h2222;
    adrs[2] = 4'd7; exps[2] = 16'h00C7;
    do_reset();
    @(negedge clk);
    giveC = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ADR_1 = adrs[k];
      wait_dv(2, 1'b0, c, ov);
      n_checks++; if (c !== 2) $display("FAIL b2b_spacing_%0d: got %0d expected 2", k, c); else n_pass++;
      n_checks++; if (com_o[2] !== exps[k]) $display("FAIL b2b_com_%0d: got %h expected %h", k, com_o[2], exps[k]); else n_pass++;
    end
    giveC = 1'b0;
  endtask

  initial begin
    reset = 1'b1; giveC = 1'b0; giveD = 1'b0; write_data = 1'b0;
    ADR_1 = '0; wr_value = '0; load_en = 1'b0; load_adr = '0; load_cmd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    preload(4'd0, 16'h1234);
    preload(4'd3, 16'h1111);
    preload(4'd7, 16'h00C7);

    test_fetch_cmd();
    test_reset();
    test_write_read();
    test_load_inflight();
    test_priority();
    test_overrun();
    test_reset_abort();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_store.md
MEM_STORE -- requirements
Module: mem_store

Interface
REQ-001 Parameter: LATENCY, default 2, cycles from request sampling to dv; legal range 1..7.
REQ-002 Parameter: DEPTH, default 16, entries in each memory; fixed to match the 4-bit address.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: giveC  input  1  command-fetch request; level, sampled in IDLE.
REQ-006 Port: giveD  input  1  operand-read request; level, sampled in IDLE.
REQ-007 Port: write_data  input  1  operand-write request; level, sampled in IDLE.
REQ-008 Port: ADR_1  input  4  address for every request type.
REQ-009 Port: wr_value  input  4  operand value to store on a write.
REQ-010 Port: load_en, load_adr, load_cmd  input  1/4/16  command-memory preload port.
REQ-011 Port: dv  output  1  one-cycle response strobe.
REQ-012 Port: com  output  16  fetched command; valid while dv=1.
REQ-013 Port: data_t  output  4  fetched operand; valid while dv=1.
REQ-014 Port: busy  output  1  high in every state other than IDLE.
REQ-015 Port: overrun  output  1  one-cycle pulse: request asserted while busy and not in RESP.

Function
REQ-016 Storage SHALL be cmd_mem (DEPTH x 16) and data_mem (DEPTH x 4).
REQ-017 FSM states SHALL be IDLE, WAIT, RESP, WR.
REQ-018 Simultaneous requests in IDLE SHALL be prioritised write_data > giveC > giveD; losers are not queued.
REQ-019 IDLE + giveC or giveD: latch ADR_1, request type, and memory word at that address; then go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-020 The response counter SHALL make dv rise exactly LATENCY cycles after the sampling edge.
REQ-021 RESP: dv=1 for exactly one cycle, then IDLE.
REQ-022 RESP for giveC: com = latched word, data_t = 0.
REQ-023 RESP for giveD: data_t = latched word, com = 0.
REQ-024 IDLE + write_data: go to WR; data_mem[ADR_1] <= wr_value on the edge leaving WR.
REQ-025 Write acknowledge: RESP follows WR, dv=1 for one cycle, com=0, data_t=wr_value.
REQ-026 A request still high in the first IDLE cycle after RESP SHALL be served again; consumers deassert on the dv edge.
REQ-027 Requests arriving in WAIT or WR SHALL be ignored and pulse overrun.
REQ-028 load_en SHALL write cmd_mem[load_adr] <= load_cmd in any state.
REQ-029 A load to an address already latched for an in-flight fetch SHALL NOT alter that fetch's response.
REQ-030 A read in IDLE the cycle after a write's RESP SHALL return the newly written value.
REQ-031 Outside RESP: dv=0 and com/data_t hold their last values.

Reset
REQ-032 Reset SHALL force state IDLE, dv=0, com=0, data_t=0, busy=0, overrun=0, counter=0.
REQ-033 Reset SHALL clear all data_mem entries to 0.
REQ-034 Reset SHALL preserve cmd_mem.
REQ-035 Reset mid-transaction SHALL abort it with no dv.
REQ-036 A write aborted by reset SHALL leave data_mem all-zero, with no write.
REQ-037 reset SHALL override load_en in the same cycle.

Structure
REQ-038 Package mem_pkg SHALL hold the state enum, ADR_W=4, CMD_W=16, DAT_W=4, DEPTH, and the request-type enum.
REQ-039 Sub-module resp_timer (3-bit down-counter: load, done) SHALL implement the latency; everything else lives in mem_store.

Verification
REQ-040 load cmd_mem[0]=16'h1234; giveC=1, ADR_1=0 at t -> dv=1 at t+2 only, com=16'h1234.
REQ-041 write_data=1, ADR_1=5, wr_value=4'hA -> dv ack with data_t=4'hA; then giveD, ADR_1=5 -> data_t=4'hA.
REQ-042 giveC and giveD and write_data all high in IDLE -> write served first; giveC held -> served next; giveD served last.
REQ-043 giveD issued during WAIT (LATENCY=3) -> overrun pulses once; only the original response occurs.
REQ-044 reset asserted in WAIT -> no dv, busy=0 next cycle, data_mem all zero, cmd_mem[0] still 16'h1234.
REQ-045 LATENCY=1 back-to-back giveC held 3 fetches -> dv every other cycle, addresses as presented.
